jtpang_dmagrant: RTL and testbench

- Responder side of the object-DMA bus handshake.
- Receives busrq from the object engine and waits for the current CPU memory/IO cycle to finish. It then freezes the CPU and answers with busak_n.
- While granted, steers the shared VRAM address port to dma_addr. Sits between the CPU core, the VRAM/attr RAM and the video block.

---
 rtl/jtpang_dma_pkg.sv | 14 +
 rtl/jtpang_dmagrant_cnt.sv | 36 +++
 rtl/jtpang_dmagrant.sv | 109 ++++++++++
 tb/tb_jtpang_dmagrant.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtpang_dma_pkg.sv
// Shared types and defaults for the object-DMA bus grant logic.
package jtpang_dma_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } dma_state_t;

  localparam int unsigned DMA_AW   = 9;
  localparam int unsigned DMA_TOUT = 2048;

endpackage

// File: rtl/jtpang_dmagrant_cnt.sv
// Saturating grant-length timer: cleared while idle, counts granted cycles,
// flags the last allowed cycle of a grant.
module jtpang_dmagrant_cnt
  import jtpang_dma_pkg::*;
#(
  parameter int unsigned TOUT = DMA_TOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int unsigned   CW   = (TOUT > 1) ? $clog2(TOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TOUT - 1);

  logic [CW-1:0] cnt;

  // Count granted cycles; stop at LAST so the counter can never wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !hit) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Last permitted grant cycle reached
  always_comb begin
    hit = (cnt == LAST);
  end

endmodule

// File: rtl/jtpang_dmagrant.sv
// Object-DMA bus responder: waits for a free CPU cycle, freezes the CPU,
// acknowledges the request and steers the VRAM address port to the DMA side.
module jtpang_dmagrant
  import jtpang_dma_pkg::*;
#(
  parameter int unsigned AW   = 12,
  parameter int unsigned DW   = DMA_AW,
  parameter int unsigned TOUT = DMA_TOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_cen,
  input  logic          mreq_n,
  input  logic          iorq_n,
  input  logic          busrq,
  output logic          busak_n,
  output logic          cpu_hold,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] dma_addr,
  output logic [AW-1:0] ram_addr,
  input  logic          cpu_wr_n,
  output logic          ram_we,
  output logic          tout_err
);

  dma_state_t state, state_nx;
  logic       hold_off;
  logic       set_tout;
  logic       cpu_idle;
  logic       cnt_clr;
  logic       cnt_en;
  logic       cnt_hit;

  // A CPU cycle boundary with no memory or IO access in progress
  always_comb begin
    cpu_idle = cpu_cen & mreq_n & iorq_n;
    cnt_clr  = (state == IDLE);
    cnt_en   = (state == GRANT);
  end

  jtpang_dmagrant_cnt #(
    .TOUT (TOUT)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .hit   (cnt_hit)
  );

  // State register, sticky timeout flag and lockout after a forced release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tout_err <= 1'b0;
      hold_off <= 1'b0;
    end else begin
      state <= state_nx;
      if (set_tout) begin
        tout_err <= 1'b1;
        hold_off <= 1'b1;
      end else if (!busrq) begin
        hold_off <= 1'b0;
      end
    end
  end

  // Next state; a request dropping on the timeout cycle is a normal release
  always_comb begin
    state_nx = state;
    set_tout = 1'b0;
    case (state)
      IDLE: begin
        if (busrq && !hold_off) state_nx = WAIT;
      end
      WAIT: begin
        if (!busrq)        state_nx = IDLE;
        else if (cpu_idle) state_nx = GRANT;
      end
      GRANT: begin
        if (!busrq) begin
          state_nx = RELEASE;
        end else if (cnt_hit) begin
          state_nx = RELEASE;
          set_tout = 1'b1;
        end
      end
      RELEASE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Handshake outputs and VRAM port mux; DMA side never writes
  always_comb begin
    busak_n  = (state != GRANT);
    cpu_hold = (state == GRANT) || (state == RELEASE);
    ram_addr = cpu_addr;
    ram_we   = !cpu_wr_n;
    if (cpu_hold) begin
      ram_addr = AW'(dma_addr);
      ram_we   = 1'b0;
    end
  end

endmodule

// File: tb/tb_jtpang_dmagrant.sv
// Bench for jtpang_dmagrant: directed handshake sequences, a table of mux
// vectors and randomized traffic against a reference model. Two instances
// share stimulus: one with the default timeout and one with TOUT=16.
module tb_jtpang_dmagrant;

  localparam int unsigned TOUT_A = 2048;
  localparam int unsigned TOUT_B = 16;

  logic        clk = 1'b0;
  logic        rst_n, cpu_cen, mreq_n, iorq_n, busrq, cpu_wr_n;
  logic [11:0] cpu_addr;
  logic [8:0]  dma_addr;

  logic        a_busak_n, a_cpu_hold, a_ram_we, a_tout_err;
  logic [11:0] a_ram_addr;
  logic        b_busak_n, b_cpu_hold, b_ram_we, b_tout_err;
  logic [11:0] b_ram_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  jtpang_dmagrant #(.AW(12), .DW(9), .TOUT(TOUT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .cpu_cen(cpu_cen), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .busrq(busrq), .busak_n(a_busak_n), .cpu_hold(a_cpu_hold), .cpu_addr(cpu_addr),
    .dma_addr(dma_addr), .ram_addr(a_ram_addr), .cpu_wr_n(cpu_wr_n), .ram_we(a_ram_we),
    .tout_err(a_tout_err)
  );

  jtpang_dmagrant #(.AW(12), .DW(9), .TOUT(TOUT_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .cpu_cen(cpu_cen), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .busrq(busrq), .busak_n(b_busak_n), .cpu_hold(b_cpu_hold), .cpu_addr(cpu_addr),
    .dma_addr(dma_addr), .ram_addr(b_ram_addr), .cpu_wr_n(cpu_wr_n), .ram_we(b_ram_we),
    .tout_err(b_tout_err)
  );

  // Reference model: who owns the bus, how long the DMA side has had it,
  // whether a timed-out requester must first let go of busrq.
  logic        m_gnt [2];
  logic        m_rel [2];
  logic        m_wait[2];
  logic        m_blk [2];
  logic        m_err [2];
  int unsigned m_len [2];

  function automatic int unsigned tout_of(input int k);
    return (k == 0) ? TOUT_A : TOUT_B;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_gnt[k] <= 1'b0; m_rel[k] <= 1'b0; m_wait[k] <= 1'b0;
        m_blk[k] <= 1'b0; m_err[k] <= 1'b0; m_len[k]  <= 0;
      end else begin
        if (m_rel[k]) begin
          m_rel[k] <= 1'b0;
        end else if (m_gnt[k]) begin
          m_len[k] <= m_len[k] + 32'd1;
          if (!busrq) begin
            m_gnt[k] <= 1'b0; m_rel[k] <= 1'b1;
          end else if (m_len[k] + 32'd1 == tout_of(k)) begin
            m_gnt[k] <= 1'b0; m_rel[k] <= 1'b1; m_err[k] <= 1'b1; m_blk[k] <= 1'b1;
          end
        end else if (m_wait[k]) begin
          if (!busrq) begin
            m_wait[k] <= 1'b0;
          end else if (cpu_cen && mreq_n && iorq_n) begin
            m_wait[k] <= 1'b0; m_gnt[k] <= 1'b1; m_len[k] <= 0;
          end
        end else if (busrq && !m_blk[k]) begin
          m_wait[k] <= 1'b1;
        end
        if (!busrq) m_blk[k] <= 1'b0;
      end
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk12(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
    end
  endtask

  // One clock; also checks cpu_hold did not move across an edge where the
  // CPU was mid-access on a cpu_cen.
  task automatic tick();
    logic busy, ha, hb;
    busy = cpu_cen && (!mreq_n || !iorq_n);
    ha   = a_cpu_hold;
    hb   = b_cpu_hold;
    @(posedge clk);
    #1;
    if (busy) begin
      chk1("hold_stable_a", a_cpu_hold, ha);
      chk1("hold_stable_b", b_cpu_hold, hb);
    end
  endtask

  task automatic chk_model(input int k, input string tag, input logic bk, input logic hd,
                           input logic er, input logic [11:0] ad, input logic we);
    logic he;
    he = m_gnt[k] | m_rel[k];
    chk1({tag, "_busak_n"}, bk, !m_gnt[k]);
    chk1({tag, "_cpu_hold"}, hd, he);
    chk1({tag, "_tout_err"}, er, m_err[k]);
    chk12({tag, "_ram_addr"}, ad, he ? 12'(dma_addr) : cpu_addr);
    chk1({tag, "_ram_we"}, we, !he && !cpu_wr_n);
  endtask

  typedef struct {
    logic        in_grant;
    logic [11:0] cpu_addr;
    logic        cpu_wr_n;
    logic [8:0]  dma_addr;
    logic [11:0] exp_addr;
    logic        exp_we;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int glen, bad;
    logic granted;

    vecs[0] = '{1'b0, 12'hC42, 1'b0, 9'h1A5, 12'hC42, 1'b1};
    vecs[1] = '{1'b0, 12'h000, 1'b1, 9'h1FF, 12'h000, 1'b0};
    vecs[2] = '{1'b0, 12'hFFF, 1'b0, 9'h000, 12'hFFF, 1'b1};
    vecs[3] = '{1'b0, 12'h5A5, 1'b1, 9'h0F0, 12'h5A5, 1'b0};
    vecs[4] = '{1'b1, 12'hC42, 1'b0, 9'h1A5, 12'h1A5, 1'b0};
    vecs[5] = '{1'b1, 12'hFFF, 1'b0, 9'h1FF, 12'h1FF, 1'b0};
    vecs[6] = '{1'b1, 12'h123, 1'b1, 9'h000, 12'h000, 1'b0};
    vecs[7] = '{1'b1, 12'hABC, 1'b0, 9'h0F0, 12'h0F0, 1'b0};

    rst_n = 1'b0; busrq = 1'b1; cpu_cen = 1'b0; mreq_n = 1'b1; iorq_n = 1'b1;
    cpu_wr_n = 1'b1; cpu_addr = '0; dma_addr = '0;

    // Reset with a request pending, then first grant
    repeat (3) tick();
    chk1("rst_busak_n", a_busak_n, 1'b1);
    chk1("rst_cpu_hold", a_cpu_hold, 1'b0);
    chk1("rst_tout_err", a_tout_err, 1'b0);
    chk1("rst_busak_n_b", b_busak_n, 1'b1);
    rst_n = 1'b1;
    tick();
    chk1("wait_no_grant", a_busak_n, 1'b1);
    cpu_cen = 1'b1; tick(); cpu_cen = 1'b0;
    chk1("first_grant_busak_n", a_busak_n, 1'b0);
    chk1("first_grant_hold", a_cpu_hold, 1'b1);
    busrq = 1'b0; tick(); tick();

    // Request while the CPU is mid-access
    mreq_n = 1'b0; busrq = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      cpu_cen = 1'b1; tick(); cpu_cen = 1'b0;
      chk1("busy_no_grant", a_busak_n, 1'b1);
      tick();
    end
    mreq_n = 1'b1; cpu_addr = 12'hC42; cpu_wr_n = 1'b0; dma_addr = 9'h1A5;
    cpu_cen = 1'b1; tick(); cpu_cen = 1'b0;
    chk1("free_grant_busak_n", a_busak_n, 1'b0);
    chk12("grant_ram_addr", a_ram_addr, 12'h1A5);
    chk1("grant_ram_we", a_ram_we, 1'b0);

    // Long grant, normal release
    bad = 0;
    repeat (299) begin
      tick();
      if (a_busak_n) bad++;
    end
    chk12("long_grant_drops", 12'(bad), 12'd0);
    chk1("long_grant_no_tout", a_tout_err, 1'b0);
    busrq = 1'b0; tick();
    chk1("rel_busak_n", a_busak_n, 1'b1);
    chk1("rel_hold_kept", a_cpu_hold, 1'b1);
    chk12("rel_ram_addr", a_ram_addr, 12'h1A5);
    tick();
    chk1("rel_hold_off", a_cpu_hold, 1'b0);
    chk12("rel_cpu_addr", a_ram_addr, 12'hC42);
    chk1("rel_ram_we", a_ram_we, 1'b1);

    // Timeout on the TOUT=16 instance
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    busrq = 1'b1; tick();
    cpu_cen = 1'b1; tick(); cpu_cen = 1'b0;
    chk1("tout_grant_start", b_busak_n, 1'b0);
    glen = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (b_busak_n) break;
      glen++;
    end
    chk12("tout_grant_len", 12'(glen), 12'd16);
    chk1("tout_err_set", b_tout_err, 1'b1);
    chk1("tout_hold_release", b_cpu_hold, 1'b1);
    chk1("tout_a_unaffected", a_tout_err, 1'b0);
    bad = 0;
    for (int i = 0; i < 22; i++) begin
      cpu_cen = i[0];
      tick();
      if (!b_busak_n) bad++;
    end
    cpu_cen = 1'b0;
    chk12("tout_no_regrant", 12'(bad), 12'd0);
    busrq = 1'b0; tick(); tick();
    busrq = 1'b1; tick();
    cpu_cen = 1'b1; tick(); cpu_cen = 1'b0;
    chk1("tout_regrant", b_busak_n, 1'b0);
    chk1("tout_err_sticky", b_tout_err, 1'b1);

    // Request abandoned while still waiting
    busrq = 1'b0; tick(); tick(); tick();
    mreq_n = 1'b0; cpu_cen = 1'b1; busrq = 1'b1;
    tick();
    chk1("abort_busak_n_1", a_busak_n, 1'b1);
    tick();
    chk1("abort_busak_n_2", a_busak_n, 1'b1);
    busrq = 1'b0; tick();
    chk1("abort_hold", a_cpu_hold, 1'b0);
    mreq_n = 1'b1; busrq = 1'b1; tick();
    chk1("abort_back_idle", a_busak_n, 1'b1);
    tick();
    chk1("abort_then_grant", a_busak_n, 1'b0);
    cpu_cen = 1'b0;

    // Asynchronous reset in the middle of a grant
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk1("async_busak_n", a_busak_n, 1'b1);
    chk1("async_hold", a_cpu_hold, 1'b0);
    chk1("async_tout_clr", b_tout_err, 1'b0);
    chk1("async_busak_n_b", b_busak_n, 1'b1);
    rst_n = 1'b1; busrq = 1'b0;
    tick();

    // Address / write-enable mux vectors
    granted = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].in_grant && !granted) begin
        busrq = 1'b1; tick();
        cpu_cen = 1'b1; tick(); cpu_cen = 1'b0;
        granted = 1'b1;
      end
      cpu_addr = vecs[i].cpu_addr; cpu_wr_n = vecs[i].cpu_wr_n; dma_addr = vecs[i].dma_addr;
      #1;
      chk12($sformatf("vec%0d_ram_addr", i), a_ram_addr, vecs[i].exp_addr);
      chk1($sformatf("vec%0d_ram_we", i), a_ram_we, vecs[i].exp_we);
    end
    busrq = 1'b0; tick(); tick();

    // Randomized traffic against the model
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      tick();
      chk_model(0, "rnd_a", a_busak_n, a_cpu_hold, a_tout_err, a_ram_addr, a_ram_we);
      chk_model(1, "rnd_b", b_busak_n, b_cpu_hold, b_tout_err, b_ram_addr, b_ram_we);
      cpu_cen = ($urandom_range(0, 2) == 0);
      if (a_cpu_hold || b_cpu_hold) begin
        mreq_n = 1'b1; iorq_n = 1'b1;
      end else begin
        mreq_n = 1'($urandom_range(0, 1));
        iorq_n = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 24) == 0) busrq = !busrq;
      cpu_addr = 12'($urandom);
      dma_addr = 9'($urandom);
      cpu_wr_n = 1'($urandom_range(0, 1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
